// File: rtl/stream_demux_1xn_if.sv
// Stream bundle for stream_demux_1xn: one input stream and N output channels.
// master = packet source / channel consumers, slave = the demultiplexer.
interface stream_demux_1xn_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
);
    logic [WIDTH-1:0]   in_data;
    logic [SELW-1:0]    in_sel;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_last;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N packet demultiplexer; the select is latched on the head beat
// and out-of-range packets are discarded. STREAM_DEMUX_CNT_EN adds per-channel packet counters.
module stream_demux_1xn #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    stream_demux_1xn_if.slave   bus,
    output logic                busy,
    output logic                drop,
    output logic [N*16-1:0]     pkt_cnt
);
    localparam int unsigned NP    = 1 << SELW;
    localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

    if (N < 2 || N > 16 || N > NP) begin : g_bad_param
        $error("stream_demux_1xn: need 2 <= N <= 16 and N <= 2**SELW");
    end

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                     state_q, state_d;
    logic [SELW-1:0]            cur_sel_q, cur_sel_d;
    logic                       drop_q, drop_d;
    logic [N-1:0]               out_valid_q;
    logic [N-1:0]               out_last_q;
    logic [N-1:0][WIDTH-1:0]    out_data_q;

    logic [N-1:0]               slot_free;
    logic [NP-1:0]              free_pad;
    logic                       sel_ok;
    logic                       in_ready_c;
    logic                       xfer;
    logic                       load;
    logic [SELW-1:0]            load_sel;

    assign slot_free = ~out_valid_q | bus.out_ready;
    assign free_pad  = NP'(slot_free);
    assign sel_ok    = ({1'b0, bus.in_sel} < N_EXT);
    assign xfer      = bus.in_valid && in_ready_c;

    // Next-state, input ready and load steering
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        drop_d     = 1'b0;
        in_ready_c = 1'b0;
        load       = 1'b0;
        load_sel   = cur_sel_q;
        unique case (state_q)
            IDLE: begin
                in_ready_c = sel_ok ? free_pad[bus.in_sel] : 1'b1;
                if (xfer) begin
                    if (!sel_ok) begin
                        if (bus.in_last) drop_d  = 1'b1;
                        else             state_d = DROP;
                    end else begin
                        load      = 1'b1;
                        load_sel  = bus.in_sel;
                        cur_sel_d = bus.in_sel;
                        if (!bus.in_last) state_d = ROUTE;
                    end
                end
            end
            ROUTE: begin
                in_ready_c = free_pad[cur_sel_q];
                if (xfer) begin
                    load = 1'b1;
                    if (bus.in_last) state_d = IDLE;
                end
            end
            DROP: begin
                in_ready_c = 1'b1;
                if (xfer && bus.in_last) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            drop_q    <= drop_d;
        end
    end

    // One-deep output slot per channel; data/last hold their value once drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_last_q  <= '0;
            out_data_q  <= '0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                if (load && load_sel == SELW'(k)) begin
                    out_valid_q[k] <= 1'b1;
                    out_last_q[k]  <= bus.in_last;
                    out_data_q[k]  <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    out_valid_q[k] <= 1'b0;
                end
            end
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [N-1:0][15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                if (out_valid_q[k] && bus.out_ready[k] && out_last_q[k])
                    cnt_q[k] <= cnt_q[k] + 16'd1;
            end
        end
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != IDLE);
    assign drop          = drop_q;
endmodule

// File: tb/tb_stream_demux_1xn.sv
// Directed bench for stream_demux_1xn: a vector table on a 4-channel instance plus
// hand sequences for dropped packets (3-channel instance), mid-packet reset and counters.
module tb_stream_demux_1xn;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    stream_demux_1xn_if #(.WIDTH(8), .N(4), .SELW(2)) b4 ();
    stream_demux_1xn_if #(.WIDTH(8), .N(3), .SELW(2)) b3 ();

    logic        busy4, drop4, busy3, drop3;
    logic [63:0] cnt4;
    logic [47:0] cnt3;

    stream_demux_1xn #(.WIDTH(8), .N(4), .SELW(2)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave), .busy(busy4), .drop(drop4), .pkt_cnt(cnt4)
    );
    stream_demux_1xn #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave), .busy(busy3), .drop(drop3), .pkt_cnt(cnt3)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic        l;
        logic [3:0]  rdy;
        logic        e_ir;
        logic [3:0]  e_v;
        logic [3:0]  e_l;
        logic [31:0] e_d;
        logic        e_b;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic [1:0] sel, input logic [7:0] d,
                          input logic l, input logic [3:0] rdy);
        b4.in_valid = v; b4.in_sel = sel; b4.in_data = d; b4.in_last = l; b4.out_ready = rdy;
    endtask

    task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] d,
                          input logic l, input logic [2:0] rdy);
        b3.in_valid = v; b3.in_sel = sel; b3.in_data = d; b3.in_last = l; b3.out_ready = rdy;
    endtask

    initial begin
        // {valid, sel, data, last, out_ready, exp in_ready, exp out_valid, exp out_last, exp out_data, exp busy}
        vt[0]  = '{1'b1, 2'd0, 8'hA0, 1'b1, 4'hF, 1'b1, 4'b0001, 4'b0001, 32'h000000A0, 1'b0};
        vt[1]  = '{1'b1, 2'd1, 8'hA1, 1'b1, 4'hF, 1'b1, 4'b0010, 4'b0011, 32'h0000A1A0, 1'b0};
        vt[2]  = '{1'b1, 2'd2, 8'hA2, 1'b1, 4'hF, 1'b1, 4'b0100, 4'b0111, 32'h00A2A1A0, 1'b0};
        vt[3]  = '{1'b1, 2'd3, 8'hA3, 1'b1, 4'hF, 1'b1, 4'b1000, 4'b1111, 32'hA3A2A1A0, 1'b0};
        vt[4]  = '{1'b1, 2'd2, 8'h11, 1'b0, 4'hF, 1'b1, 4'b0100, 4'b1011, 32'hA311A1A0, 1'b1};
        vt[5]  = '{1'b1, 2'd1, 8'h22, 1'b0, 4'hF, 1'b1, 4'b0100, 4'b1011, 32'hA322A1A0, 1'b1};
        vt[6]  = '{1'b1, 2'd1, 8'h33, 1'b1, 4'hF, 1'b1, 4'b0100, 4'b1111, 32'hA333A1A0, 1'b0};
        vt[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 4'b1111, 32'hA333A1A0, 1'b0};
        vt[8]  = '{1'b1, 2'd1, 8'h44, 1'b1, 4'hD, 1'b1, 4'b0010, 4'b1111, 32'hA33344A0, 1'b0};
        vt[9]  = '{1'b1, 2'd1, 8'h55, 1'b1, 4'hD, 1'b0, 4'b0010, 4'b1111, 32'hA33344A0, 1'b0};
        vt[10] = '{1'b1, 2'd1, 8'h55, 1'b1, 4'hD, 1'b0, 4'b0010, 4'b1111, 32'hA33344A0, 1'b0};
        vt[11] = '{1'b1, 2'd1, 8'h55, 1'b1, 4'hF, 1'b1, 4'b0010, 4'b1111, 32'hA33355A0, 1'b0};
        vt[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 4'b1111, 32'hA33355A0, 1'b0};

        drive4(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
        drive3(1'b0, 2'd0, 8'h00, 1'b0, 3'h7);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", 64'(b4.out_valid), 64'd0);
        chk("reset out_last", 64'(b4.out_last), 64'd0);
        chk("reset out_data", 64'(b4.out_data), 64'd0);
        chk("reset busy", 64'(busy4), 64'd0);
        chk("reset drop", 64'(drop4), 64'd0);
        chk("reset pkt_cnt", cnt4, 64'd0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive4(vt[i].v, vt[i].sel, vt[i].d, vt[i].l, vt[i].rdy);
            #1;
            chk($sformatf("vec%0d in_ready", i), 64'(b4.in_ready), 64'(vt[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 64'(b4.out_valid), 64'(vt[i].e_v));
            chk($sformatf("vec%0d out_last", i), 64'(b4.out_last), 64'(vt[i].e_l));
            chk($sformatf("vec%0d out_data", i), 64'(b4.out_data), 64'(vt[i].e_d));
            chk($sformatf("vec%0d busy", i), 64'(busy4), 64'(vt[i].e_b));
            chk($sformatf("vec%0d drop", i), 64'(drop4), 64'd0);
        end

        // Two-beat packet to an absent channel on the N=3 instance
        @(negedge clk);
        drive3(1'b1, 2'd3, 8'h5A, 1'b0, 3'h7);
        #1 chk("drop2 head in_ready", 64'(b3.in_ready), 64'd1);
        @(posedge clk); #1;
        chk("drop2 head busy", 64'(busy3), 64'd1);
        chk("drop2 head drop", 64'(drop3), 64'd0);
        chk("drop2 head out_valid", 64'(b3.out_valid), 64'd0);
        @(negedge clk);
        drive3(1'b1, 2'd0, 8'h5B, 1'b1, 3'h7);
        #1 chk("drop2 last in_ready", 64'(b3.in_ready), 64'd1);
        @(posedge clk); #1;
        chk("drop2 pulse", 64'(drop3), 64'd1);
        chk("drop2 busy after", 64'(busy3), 64'd0);
        chk("drop2 out_valid", 64'(b3.out_valid), 64'd0);
        @(negedge clk);
        drive3(1'b0, 2'd0, 8'h00, 1'b0, 3'h7);
        @(posedge clk); #1;
        chk("drop2 pulse ends", 64'(drop3), 64'd0);

        // Single-beat dropped packet, then a good packet on the highest channel
        @(negedge clk);
        drive3(1'b1, 2'd3, 8'h5C, 1'b1, 3'h7);
        @(posedge clk); #1;
        chk("drop1 busy", 64'(busy3), 64'd0);
        chk("drop1 pulse", 64'(drop3), 64'd1);
        @(negedge clk);
        drive3(1'b1, 2'd2, 8'h66, 1'b1, 3'h7);
        @(posedge clk); #1;
        chk("n3 ch2 drop clear", 64'(drop3), 64'd0);
        chk("n3 ch2 out_valid", 64'(b3.out_valid), 64'b100);
        chk("n3 ch2 out_data", 64'(b3.out_data), 64'h660000);
        @(negedge clk);
        drive3(1'b0, 2'd0, 8'h00, 1'b0, 3'h7);

        // Reset in the middle of a stalled packet on channel 0
        drive4(1'b1, 2'd0, 8'h01, 1'b0, 4'b1110);
        @(posedge clk); #1;
        chk("mid head out_valid", 64'(b4.out_valid), 64'b0001);
        chk("mid head busy", 64'(busy4), 64'd1);
        @(negedge clk);
        drive4(1'b1, 2'd0, 8'h02, 1'b0, 4'b1110);
        #1 chk("mid stall in_ready", 64'(b4.in_ready), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid rst out_valid", 64'(b4.out_valid), 64'd0);
        chk("mid rst busy", 64'(busy4), 64'd0);
        chk("mid rst out_data", 64'(b4.out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive4(1'b1, 2'd1, 8'h77, 1'b1, 4'hF);
        #1 chk("post rst in_ready", 64'(b4.in_ready), 64'd1);
        @(posedge clk); #1;
        chk("post rst out_valid", 64'(b4.out_valid), 64'b0010);
        chk("post rst out_data", 64'(b4.out_data), 64'h00007700);
        chk("post rst busy", 64'(busy4), 64'd0);
        @(negedge clk);
        drive4(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);

`ifdef STREAM_DEMUX_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive4(1'b1, 2'd3, 8'hC3, 1'b1, 4'hF);
        repeat (65537) @(posedge clk);
        @(negedge clk);
        drive4(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        chk("cnt ch3 wrap", 64'(cnt4[63:48]), 64'd1);
        chk("cnt others", 64'(cnt4[47:0]), 64'd0);
`else
        @(posedge clk); #1;
        chk("cnt4 tied", cnt4, 64'd0);
        chk("cnt3 tied", 64'(cnt3), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
